// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register-file read, load-use stall,
// flush handling and a HALT state, feeding the ID/EX pipeline register.
`default_nettype none

module decode_stage #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      Inst_In,
  input  logic             Inst_Valid,
  input  logic             Flush,
  output logic [RSIZE-1:0] RAddr1,
  output logic [RSIZE-1:0] RAddr2,
  input  logic [DSIZE-1:0] RData1,
  input  logic [DSIZE-1:0] RData2,
  output logic             Stall_Out,
  output logic             EX_Valid,
  output logic [3:0]       EX_Op,
  output logic [RSIZE-1:0] EX_WAddr,
  output logic             EX_Wen,
  output logic             EX_MemRd,
  output logic             EX_MemWr,
  output logic [DSIZE-1:0] EX_A,
  output logic [DSIZE-1:0] EX_B,
  output logic [DSIZE-1:0] EX_Imm,
  output logic             EX_Halt
);

  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LHB  = 4'b1010;
  localparam logic [3:0] OP_LLB  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t state, state_next;

  logic [3:0]       op;
  logic [RSIZE-1:0] rd, rs1, rs2;
  logic [DSIZE-1:0] imm;
  logic             writes_rd;
  logic             wen;
  logic             hz;
  logic             halted;
  logic             load;

  assign op  = Inst_In[15:12];
  assign rd  = RSIZE'(Inst_In[11:8]);
  assign rs1 = RSIZE'(Inst_In[7:4]);
  assign rs2 = RSIZE'(Inst_In[3:0]);

  always_comb begin
    RAddr1    = '0;
    RAddr2    = '0;
    imm       = '0;
    writes_rd = 1'b0;
    if (op[3:2] == 2'b00) begin
      RAddr1    = rs1;
      RAddr2    = rs2;
      writes_rd = 1'b1;
    end else if (op[3:2] == 2'b01) begin
      RAddr1    = rs1;
      imm       = DSIZE'(Inst_In[3:0]);
      writes_rd = 1'b1;
    end else begin
      case (op)
        OP_LW: begin
          RAddr1    = rs1;
          imm       = {{(DSIZE-4){Inst_In[3]}}, Inst_In[3:0]};
          writes_rd = 1'b1;
        end
        OP_SW: begin
          RAddr1 = rs1;
          RAddr2 = rd;
          imm    = {{(DSIZE-4){Inst_In[3]}}, Inst_In[3:0]};
        end
        OP_LHB: begin
          RAddr1    = rd;
          imm       = DSIZE'({Inst_In[7:0], 8'h00});
          writes_rd = 1'b1;
        end
        OP_LLB: begin
          imm       = {{(DSIZE-8){Inst_In[7]}}, Inst_In[7:0]};
          writes_rd = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wen = writes_rd && (rd != '0);

  // Unused sources decode to address 0, so comparing against both read ports covers every op.
  assign hz = EX_Valid && EX_MemRd && (EX_WAddr != '0) && Inst_Valid &&
              (((RAddr1 != '0) && (RAddr1 == EX_WAddr)) ||
               ((RAddr2 != '0) && (RAddr2 == EX_WAddr)));

  assign halted    = (state == HALTED);
  assign Stall_Out = (hz || halted) && !Flush && !Reset;
  assign load      = Inst_Valid && !Flush && !hz && !halted;

  always_comb begin
    state_next = state;
    if (state == RUN && load && op == OP_HALT)
      state_next = HALTED;
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      state <= RUN;
    else
      state <= state_next;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      EX_Valid <= 1'b0;
      EX_Op    <= '0;
      EX_WAddr <= '0;
      EX_Wen   <= 1'b0;
      EX_MemRd <= 1'b0;
      EX_MemWr <= 1'b0;
      EX_A     <= '0;
      EX_B     <= '0;
      EX_Imm   <= '0;
      EX_Halt  <= 1'b0;
    end else if (load) begin
      EX_Valid <= 1'b1;
      EX_Op    <= op;
      EX_WAddr <= rd;
      EX_Wen   <= wen;
      EX_MemRd <= (op == OP_LW);
      EX_MemWr <= (op == OP_SW);
      EX_A     <= RData1;
      EX_B     <= RData2;
      EX_Imm   <= imm;
      EX_Halt  <= (op == OP_HALT);
    end else begin
      // Bubble: data fields are left as-is since nothing downstream consumes them.
      EX_Valid <= 1'b0;
      EX_Wen   <= 1'b0;
      EX_MemRd <= 1'b0;
      EX_MemWr <= 1'b0;
      EX_Halt  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter DSIZE, default 16, meaning data width.
REQ-002 The block SHALL have parameter RSIZE, default 4, meaning register address width.
REQ-003 The block SHALL have port Clock, input, 1, meaning single clock with all state on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port Inst_In, input, 16, meaning fetched instruction: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4, [7:0] imm8.
REQ-006 The block SHALL have port Inst_Valid, input, 1, meaning Inst_In is valid this cycle.
REQ-007 The block SHALL have port Flush, input, 1, meaning kill the instruction in decode (branch redirect).
REQ-008 The block SHALL have ports RAddr1 and RAddr2, output, RSIZE each, meaning combinational read addresses to the register file.
REQ-009 The block SHALL have ports RData1 and RData2, input, DSIZE each, meaning register-file read data returned in the same cycle.
REQ-010 The block SHALL have port Stall_Out, output, 1, meaning combinational; fetch holds Inst_In when it is 1.
REQ-011 The block SHALL have registered outputs EX_Valid (1), EX_Op (4), EX_WAddr (RSIZE), EX_Wen (1), EX_MemRd (1), EX_MemWr (1), EX_A (DSIZE), EX_B (DSIZE), EX_Imm (DSIZE) and EX_Halt (1), meaning the ID/EX pipeline register.

Function
REQ-012 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND and 0011 OR (rd=rs1 op rs2); 0100 SLL, 0101 SRL, 0110 SRA and 0111 ROR (rd=rs1 shifted by imm4); 1000 LW rd,imm4(rs1); 1001 SW rd,imm4(rs1); 1010 LHB; 1011 LLB; 1100-1110 reserved (decode as NOP); 1111 HALT.
REQ-013 Read addresses SHALL be: R-type RAddr1=rs1 and RAddr2=rs2; shift and LW RAddr1=rs1 and RAddr2=0; SW RAddr1=rs1 and RAddr2=rd; LHB RAddr1=rd and RAddr2=0; LLB, reserved and HALT RAddr1=RAddr2=0.
REQ-014 EX_Imm SHALL be: imm4 zero-extended for shifts; imm4 sign-extended for LW and SW; {imm8,8'h00} for LHB (EX sets rd=EX_Imm|(EX_A&16'h00FF)); imm8 sign-extended for LLB; 0 otherwise.
REQ-015 EX_Wen SHALL be 1 only for ALU, shift, LW, LHB and LLB with rd!=0, and a write to R0 SHALL never be issued.
REQ-016 EX_MemRd SHALL be 1 only for LW, and EX_MemWr SHALL be 1 only for SW.
REQ-017 Load-use hazard: hz SHALL be 1 when EX_Valid & EX_MemRd & EX_WAddr!=0 & Inst_Valid & (EX_WAddr matches a source used by the decoding op per REQ-013, excluding address 0).
REQ-018 Stall_Out SHALL equal (hz | state==HALTED) & !Flush.
REQ-019 On a clock edge with stall from hz, the block SHALL load a bubble into ID/EX (EX_Valid=0, EX_Wen=0, EX_MemRd=0, EX_MemWr=0, EX_Halt=0), which limits load-use latency to exactly 1 bubble.
REQ-020 On a clock edge with Flush=1, the block SHALL load a bubble, and Flush SHALL take priority over stall and over Inst_Valid.
REQ-021 On a clock edge with Inst_Valid=0, the block SHALL load a bubble.
REQ-022 Otherwise the block SHALL load the decoded fields with EX_Valid=1, EX_A=RData1 and EX_B=RData2, giving a latency of 1 cycle from Inst_In to EX_*.
REQ-023 When in RUN, the block SHALL move to HALTED when HALT is loaded (EX_Halt=1 for that one cycle), unless Flush is asserted on that edge.
REQ-024 When in HALTED, the block SHALL hold Stall_Out=1, SHALL load only bubbles, and SHALL leave HALTED only through Reset, except that Flush SHALL drop Stall_Out to 0 for that cycle while the state stays HALTED.
REQ-025 Reserved opcodes SHALL propagate with EX_Valid=1 and all enables 0.

Reset
REQ-026 On a clock edge with Reset=1, the block SHALL set state=RUN and all EX_* outputs to 0, regardless of Flush, Inst_Valid or hazard.
REQ-027 During Reset=1, Stall_Out SHALL be 0, while RAddr1 and RAddr2 stay combinational from Inst_In.

Verification
REQ-028 The bench SHALL check: Inst_In=16'h0123 (ADD r1,r2,r3), RData1=5, RData2=7 -> RAddr1=2 and RAddr2=3, then next cycle EX_Valid=1, EX_Op=0, EX_WAddr=1, EX_Wen=1, EX_A=5 and EX_B=7.
REQ-029 The bench SHALL check: LW r4,2(r1) (16'h8412) followed by ADD r5,r4,r0 (16'h0540) -> Stall_Out=1 for exactly 1 cycle, one bubble (EX_Valid=0), then ADD issues.
REQ-030 The bench SHALL check: LW r0,0(r1) followed by ADD r5,r0,r0 -> no stall, and the LW has EX_Wen=0.
REQ-031 The bench SHALL check: Flush=1 coincident with a load-use hazard -> Stall_Out=0 and EX_Valid=0 next cycle.
REQ-032 The bench SHALL check: LLB r2,8'hF0 (16'hB2F0) -> EX_Imm=16'hFFF0, RAddr1=0 and EX_Wen=1, and LHB r2,8'h12 -> RAddr1=2 and EX_Imm=16'h1200.
REQ-033 The bench SHALL check: HALT (16'hF000) -> EX_Halt=1 for one cycle, then Stall_Out stays 1 with EX_Valid=0, and Reset returns Stall_Out=0 with all EX_* at 0.
